// File: rtl/bitblaster_pkg.sv
// ============================================================================
// Module      : bitblaster_pkg
// Description : Shared types and constants for the bit-blaster datapath control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitblaster_pkg;

    localparam int DATA_W = 10;

    localparam logic [1:0] CLS_REG  = 2'b00;
    localparam logic [1:0] CLS_ADDI = 2'b10;
    localparam logic [1:0] CLS_SUBI = 2'b11;

    typedef enum logic [3:0] {
        LOAD = 4'b0000,
        COPY = 4'b0001,
        ADD  = 4'b0010,
        SUB  = 4'b0011,
        INV  = 4'b0100,
        FLP  = 4'b0101,
        AND  = 4'b0110,
        OR   = 4'b0111,
        XOR  = 4'b1000,
        NAND = 4'b1001,
        NOR  = 4'b1010,
        XNOR = 4'b1011,
        ADDI = 4'b1100,
        SUBI = 4'b1101
    } alu_fn_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    // Operation shape, i.e. which timestep sequence an instruction follows
    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_CP  = 3'd1,
        OP_BIN = 3'd2,
        OP_UN  = 3'd3,
        OP_IMM = 3'd4
    } op_kind_t;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module      : instr_decode
// Description : Combinational instruction decode: IR -> operation kind,
//               X/Y one-hot register selects, ALU function, illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
    import bitblaster_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic [DATA_W-1:0]   i_ir,
    output op_kind_t            o_kind,
    output logic [NUM_REGS-1:0] o_x_oh,
    output logic [NUM_REGS-1:0] o_y_oh,
    output alu_fn_t             o_fn,
    output logic                o_illegal
);

    logic [1:0] w_cls;
    logic [3:0] w_code;

    assign w_cls  = i_ir[9:8];
    assign w_code = i_ir[3:0];

    assign o_x_oh = NUM_REGS'(1) << i_ir[7:6];
    assign o_y_oh = NUM_REGS'(1) << i_ir[5:4];

    always_comb begin
        o_kind    = OP_LD;
        o_fn      = LOAD;
        o_illegal = 1'b0;
        case (w_cls)
            CLS_ADDI: begin
                o_kind = OP_IMM;
                o_fn   = ADDI;
            end
            CLS_SUBI: begin
                o_kind = OP_IMM;
                o_fn   = SUBI;
            end
            CLS_REG: begin
                case (w_code)
                    4'd0: o_kind = OP_LD;
                    4'd1: o_kind = OP_CP;
                    4'd4, 4'd5: begin
                        o_kind = OP_UN;
                        o_fn   = alu_fn_t'(w_code);
                    end
                    4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
                        o_kind = OP_BIN;
                        o_fn   = alu_fn_t'(w_code);
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multi-timestep ALU-stage controller, falling-edge clocked.
//               Optional feature macro: ILLEGAL_TRAP_EN (sticky Illegal trap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import bitblaster_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int FN_W     = 4
) (
    input  logic                CLKb,
    input  logic                Clear,
    input  logic [DATA_W-1:0]   INST,
    input  logic                EXEC,
    output logic                IRin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                Ext,
    output logic                IMMout,
    output logic [DATA_W-1:0]   IMM,
    output logic                Ain,
    output logic                Gin,
    output logic                Gout,
    output logic [FN_W-1:0]     ALUcont,
    output logic                Done
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                Illegal
`endif
);

    tstep_t                r_state;
    tstep_t                w_state_nxt;
    logic [DATA_W-1:0]     r_ir;
    logic                  r_exec_prev;
    logic                  w_exec_edge;
    logic                  w_parked;

    op_kind_t              w_kind;
    logic [NUM_REGS-1:0]   w_x_oh;
    logic [NUM_REGS-1:0]   w_y_oh;
    alu_fn_t               w_fn;
    logic                  w_illegal;

    instr_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .i_ir      (r_ir),
        .o_kind    (w_kind),
        .o_x_oh    (w_x_oh),
        .o_y_oh    (w_y_oh),
        .o_fn      (w_fn),
        .o_illegal (w_illegal)
    );

    assign w_exec_edge = EXEC & ~r_exec_prev;
    assign IMM         = DATA_W'(r_ir[5:0]);

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_trap_set;

    assign w_parked = r_illegal;
    assign Illegal  = r_illegal;

    always_ff @(negedge CLKb) begin
        if (Clear) begin
            r_illegal <= 1'b0;
        end else if (w_trap_set) begin
            r_illegal <= 1'b1;
        end
    end
`else
    assign w_parked = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        IRin        = 1'b0;
        Rin         = '0;
        Rout        = '0;
        Ext         = 1'b0;
        IMMout      = 1'b0;
        Ain         = 1'b0;
        Gin         = 1'b0;
        Gout        = 1'b0;
        ALUcont     = '0;
        Done        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_trap_set  = 1'b0;
`endif
        case (r_state)
            T0: begin
                if (w_exec_edge && !w_parked) begin
                    IRin        = 1'b1;
                    w_state_nxt = T1;
                end
            end
            T1: begin
                w_state_nxt = T0;
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_trap_set = 1'b1;
`else
                    Done       = 1'b1;
`endif
                end else begin
                    case (w_kind)
                        OP_LD: begin
                            Ext  = 1'b1;
                            Rin  = w_x_oh;
                            Done = 1'b1;
                        end
                        OP_CP: begin
                            Rout = w_y_oh;
                            Rin  = w_x_oh;
                            Done = 1'b1;
                        end
                        OP_UN: begin
                            Rout        = w_y_oh;
                            Gin         = 1'b1;
                            ALUcont     = FN_W'(w_fn);
                            w_state_nxt = T2;
                        end
                        default: begin
                            Rout        = w_x_oh;
                            Ain         = 1'b1;
                            w_state_nxt = T2;
                        end
                    endcase
                end
            end
            T2: begin
                case (w_kind)
                    OP_UN: begin
                        Gout        = 1'b1;
                        Rin         = w_x_oh;
                        Done        = 1'b1;
                        w_state_nxt = T0;
                    end
                    OP_IMM: begin
                        IMMout      = 1'b1;
                        Gin         = 1'b1;
                        ALUcont     = FN_W'(w_fn);
                        w_state_nxt = T3;
                    end
                    OP_BIN: begin
                        Rout        = w_y_oh;
                        Gin         = 1'b1;
                        ALUcont     = FN_W'(w_fn);
                        w_state_nxt = T3;
                    end
                    default: w_state_nxt = T0;
                endcase
            end
            T3: begin
                Gout        = 1'b1;
                Rin         = w_x_oh;
                Done        = 1'b1;
                w_state_nxt = T0;
            end
            default: w_state_nxt = T0;
        endcase

        // Clear wins over everything, including a same-cycle EXEC edge
        if (Clear) begin
            IRin    = 1'b0;
            Rin     = '0;
            Rout    = '0;
            Ext     = 1'b0;
            IMMout  = 1'b0;
            Ain     = 1'b0;
            Gin     = 1'b0;
            Gout    = 1'b0;
            ALUcont = '0;
            Done    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
            w_trap_set = 1'b0;
`endif
        end
    end

    always_ff @(negedge CLKb) begin
        if (Clear) begin
            r_state     <= T0;
            r_ir        <= '0;
            r_exec_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exec_prev <= EXEC;
            if (IRin) begin
                r_ir <= INST;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit with a step-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       CLKb = 1'b0;
    logic       Clear;
    logic [9:0] INST;
    logic       EXEC;
    logic       IRin;
    logic [3:0] Rin;
    logic [3:0] Rout;
    logic       Ext;
    logic       IMMout;
    logic [9:0] IMM;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] ALUcont;
    logic       Done;
`ifdef ILLEGAL_TRAP_EN
    logic       Illegal;
`endif

    control_unit dut (
        .CLKb    (CLKb),
        .Clear   (Clear),
        .INST    (INST),
        .EXEC    (EXEC),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .Ext     (Ext),
        .IMMout  (IMMout),
        .IMM     (IMM),
        .Ain     (Ain),
        .Gin     (Gin),
        .Gout    (Gout),
        .ALUcont (ALUcont),
        .Done    (Done)
`ifdef ILLEGAL_TRAP_EN
        ,
        .Illegal (Illegal)
`endif
    );

    always #5 CLKb = ~CLKb;

    typedef struct packed {
        logic       irin;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ext;
        logic       immout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu;
        logic       done;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    trap;
    } step_t;

    step_t      q[$];
    bit         m_prev;
    logic [9:0] m_ir;
    bit         m_parked;
    bit         m_illegal;
    int         n_pass   = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done;
    int         n_irin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input outs_t o, input bit trap);
        step_t s;
        s.o    = o;
        s.trap = trap;
        q.push_back(s);
    endfunction

    // Expected per-timestep outputs of one instruction, straight from its class/FN
    function automatic void build(input logic [9:0] inst);
        logic [3:0] x, y, fn;
        logic [1:0] cls;
        outs_t      a, b, c;
        x   = 4'b0001 << inst[7:6];
        y   = 4'b0001 << inst[5:4];
        cls = inst[9:8];
        fn  = inst[3:0];
        a = '0; b = '0; c = '0;
        c.gout = 1'b1; c.rin = x; c.done = 1'b1;
        if (cls[1]) begin
            a.rout = x; a.ain = 1'b1;
            b.immout = 1'b1; b.gin = 1'b1; b.alu = cls[0] ? 4'd13 : 4'd12;
            push(a, 0); push(b, 0); push(c, 0);
        end else if (cls == 2'b01 || fn >= 4'd12) begin
`ifdef ILLEGAL_TRAP_EN
            push(a, 1);
`else
            a.done = 1'b1;
            push(a, 0);
`endif
        end else if (fn == 4'd0) begin
            a.ext = 1'b1; a.rin = x; a.done = 1'b1;
            push(a, 0);
        end else if (fn == 4'd1) begin
            a.rout = y; a.rin = x; a.done = 1'b1;
            push(a, 0);
        end else if (fn == 4'd4 || fn == 4'd5) begin
            a.rout = y; a.gin = 1'b1; a.alu = fn;
            push(a, 0); push(c, 0);
        end else begin
            a.rout = x; a.ain = 1'b1;
            b.rout = y; b.gin = 1'b1; b.alu = fn;
            push(a, 0); push(b, 0); push(c, 0);
        end
    endfunction

    task automatic cyc(input bit clr, input bit ex, input logic [9:0] inst);
        outs_t exp, obs;
        @(posedge CLKb);
        Clear = clr;
        EXEC  = ex;
        INST  = inst;
        #1;
        exp = '0;
        if (!clr) begin
            if (q.size() > 0) exp = q[0].o;
            else if (ex && !m_prev && !m_parked) exp.irin = 1'b1;
        end
        obs = {IRin, Rin, Rout, Ext, IMMout, Ain, Gin, Gout, ALUcont, Done};
        chk("outputs", {13'b0, obs}, {13'b0, exp});
        chk("imm", {22'b0, IMM}, {26'b0, m_ir[5:0]});
        chk("bus_onehot0", {31'b0, $onehot0({Ext, IMMout, Gout, |Rout}) && $onehot0(Rout)}, 32'd1);
        chk("alucont_without_gin", {31'b0, Gin || (ALUcont == 4'd0)}, 32'd1);
`ifdef ILLEGAL_TRAP_EN
        chk("illegal", {31'b0, Illegal}, {31'b0, m_illegal});
`endif
        if (Done) n_done++;
        if (IRin) n_irin++;
        if (clr) begin
            q.delete();
            m_ir = '0; m_prev = 0; m_parked = 0; m_illegal = 0;
        end else begin
            if (q.size() > 0) begin
                if (q[0].trap) begin
                    m_illegal = 1;
                    m_parked  = 1;
                end
                void'(q.pop_front());
            end else if (ex && !m_prev && !m_parked) begin
                m_ir = inst;
                build(inst);
            end
            m_prev = ex;
        end
    endtask

    initial begin
        logic [9:0] ri;
        Clear = 1'b1; EXEC = 1'b0; INST = '0;
        m_prev = 0; m_ir = '0; m_parked = 0; m_illegal = 0;
        n_done = 0; n_irin = 0;
        repeat (2) @(negedge CLKb);

        // Reset state
        cyc(1, 0, '0);
        cyc(0, 0, '0);

        // ld R2
        cyc(0, 1, 10'b00_10_00_0000);
        cyc(0, 0, '0);
        cyc(0, 0, '0);

        // add R1,R3
        cyc(0, 1, 10'b00_01_11_0010);
        repeat (4) cyc(0, 0, '0);

        // addi R0,5
        cyc(0, 1, 10'b10_00_000101);
        repeat (4) cyc(0, 0, '0);

        // cp R0,R1 with EXEC held for 10 cycles
        n_done = 0; n_irin = 0;
        repeat (10) cyc(0, 1, 10'b00_00_01_0001);
        chk("held_exec_done_count", n_done, 32'd1);
        chk("held_exec_irin_count", n_irin, 32'd1);
        cyc(0, 0, '0);

        // sub R3,R0 cleared in T2, then re-run
        cyc(0, 1, 10'b00_11_00_0011);
        cyc(0, 0, '0);
        cyc(1, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 0, '0);
        cyc(0, 1, 10'b00_11_00_0011);
        repeat (4) cyc(0, 0, '0);

        // class 01 encoding, then a later EXEC, then Clear
        cyc(0, 1, 10'b01_00_000000);
        repeat (2) cyc(0, 0, '0);
        cyc(0, 1, 10'b00_10_00_0000);
        repeat (2) cyc(0, 0, '0);
        cyc(1, 0, '0);
        cyc(0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ri = 10'($urandom);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, ri);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
